// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared helpers for the SPU op blocks: signed saturation limits and the
// add-overflow test on a sum carried one bit wider than its operands.
package elixirchip_es1_spu_pkg;

    localparam int SPU_MAX_BITS = 128;

    // Limits are returned at SPU_MAX_BITS; callers truncate to their own width.
    function automatic logic [SPU_MAX_BITS-1:0] sat_max(input int bits);
        return (SPU_MAX_BITS'(1) << (bits - 1)) - SPU_MAX_BITS'(1);
    endfunction

    function automatic logic [SPU_MAX_BITS-1:0] sat_min(input int bits);
        return ~sat_max(bits);
    endfunction

    function automatic logic add_overflow(input logic [1:0] top2);
        return top2[1] ^ top2[0];
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_nop.sv
// Pass-through op: a cke-gated delay line of LATENCY registers for data and
// valid. LATENCY=0 degenerates to wires.
module elixirchip_es1_spu_op_nop #(
    parameter int LATENCY   = 1,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid
);

    if (LATENCY == 0) begin : g_wire
        assign m_data  = s_data;
        assign m_valid = s_valid;
    end else begin : g_pipe
        logic [DATA_BITS-1:0] data_pipe  [LATENCY];
        logic                 valid_pipe [LATENCY];

        // NOTE: the delay stages are cleared on reset (not left as un-reset
        // storage) because a stale m_valid after reset would emit a phantom term.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < LATENCY; i++) begin
                    data_pipe[i]  <= '0;
                    valid_pipe[i] <= 1'b0;
                end
            end else if (cke) begin
                data_pipe[0]  <= s_data;
                valid_pipe[0] <= s_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    data_pipe[i]  <= data_pipe[i-1];
                    valid_pipe[i] <= valid_pipe[i-1];
                end
            end
        end

        assign m_data  = data_pipe[LATENCY-1];
        assign m_valid = valid_pipe[LATENCY-1];
    end

endmodule

// File: rtl/elixirchip_es1_spu_op_acc.sv
// Signed accumulator closing the SPU MAC path: sums multiplier products with
// optional saturation, a sticky overflow flag and a saturating term counter.
module elixirchip_es1_spu_op_acc
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int   LATENCY     = 2,
    parameter int   S_DATA_BITS = 64,
    parameter int   M_DATA_BITS = 64,
    parameter int   COUNT_BITS  = 16,
    parameter bit   SATURATE    = 1'b0,
    parameter       DEVICE      = "RTL",
    parameter       SIMULATION  = "false",
    parameter       DEBUG       = "false"
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic [S_DATA_BITS-1:0] s_data,
    input  logic                   s_clear,
    input  logic                   s_valid,
    output logic [M_DATA_BITS-1:0] m_data,
    output logic                   m_overflow,
    output logic [COUNT_BITS-1:0]  m_count,
    output logic                   m_valid
);

    localparam int M = M_DATA_BITS;
    localparam logic [M-1:0] ACC_MAX = M'(sat_max(M));
    localparam logic [M-1:0] ACC_MIN = M'(sat_min(M));

    logic [M-1:0]          st0_term;
    logic                  st0_clear;
    logic                  st0_valid;
    logic [M-1:0]          st1_acc;
    logic                  st1_ovf;
    logic [COUNT_BITS-1:0] st1_cnt;
    logic                  st1_valid;

    // NOTE: reset is tested before cke so it takes effect even while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            st0_term  <= '0;
            st0_clear <= 1'b0;
            st0_valid <= 1'b0;
        end else if (cke) begin
            st0_term  <= M'($signed(s_data));
            st0_clear <= s_clear;
            st0_valid <= s_valid;
        end
    end

    logic [M:0]   sum;
    logic         sum_ovf;
    logic [M-1:0] acc_next;

    // NOTE: every always_comb output gets its default first so no latch forms.
    always_comb begin
        sum      = {st1_acc[M-1], st1_acc} + {st0_term[M-1], st0_term};
        sum_ovf  = add_overflow(sum[M:M-1]);
        acc_next = sum[M-1:0];
        if (SATURATE && sum_ovf) begin
            // On overflow the extra top bit still carries the true sign.
            acc_next = sum[M] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st1_acc   <= '0;
            st1_ovf   <= 1'b0;
            st1_cnt   <= '0;
            st1_valid <= 1'b0;
        end else if (cke) begin
            st1_valid <= st0_valid;
            if (st0_valid) begin
                if (st0_clear) begin
                    st1_acc <= st0_term;
                    st1_ovf <= 1'b0;
                    st1_cnt <= COUNT_BITS'(1);
                end else begin
                    st1_acc <= acc_next;
                    st1_ovf <= st1_ovf | sum_ovf;
                    if (st1_cnt != '1) begin
                        st1_cnt <= st1_cnt + COUNT_BITS'(1);
                    end
                end
            end
        end
    end

    logic [M+COUNT_BITS:0] out_bus;

    elixirchip_es1_spu_op_nop #(
        .LATENCY   (LATENCY - 2),
        .DATA_BITS (M + 1 + COUNT_BITS)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .cke     (cke),
        .s_data  ({st1_acc, st1_ovf, st1_cnt}),
        .s_valid (st1_valid),
        .m_data  (out_bus),
        .m_valid (m_valid)
    );

    assign {m_data, m_overflow, m_count} = out_bus;

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
// Bench for the SPU accumulator: four configurations share one stimulus stream
// and are compared each cycle against an arithmetic model of the running sum.
module tb_elixirchip_es1_spu_op_acc;

    typedef struct {
        bit                 rst;
        bit                 ce;
        bit                 vld;
        bit                 clr;
        logic signed [7:0]  d;
    } stim_t;

    typedef struct {
        bit     valid;
        bit     clear;
        longint data;
    } term_t;

    localparam int P_M   [4] = '{16, 8, 8, 16};
    localparam int P_LAT [4] = '{2, 2, 2, 4};
    localparam int P_CB  [4] = '{16, 16, 16, 2};
    localparam bit P_SAT [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic              clk = 1'b0;
    logic              reset;
    logic              cke;
    logic signed [7:0] s_data;
    logic              s_clear;
    logic              s_valid;

    logic [15:0] md0, md3;
    logic [7:0]  md1, md2;
    logic [15:0] mc0, mc1, mc2;
    logic [1:0]  mc3;
    logic        mo0, mo1, mo2, mo3;
    logic        mv0, mv1, mv2, mv3;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_acc #(.LATENCY(2), .S_DATA_BITS(8), .M_DATA_BITS(16), .COUNT_BITS(16), .SATURATE(1'b0))
        u_dut0 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
                .m_data(md0), .m_overflow(mo0), .m_count(mc0), .m_valid(mv0));
    elixirchip_es1_spu_op_acc #(.LATENCY(2), .S_DATA_BITS(8), .M_DATA_BITS(8), .COUNT_BITS(16), .SATURATE(1'b1))
        u_dut1 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
                .m_data(md1), .m_overflow(mo1), .m_count(mc1), .m_valid(mv1));
    elixirchip_es1_spu_op_acc #(.LATENCY(2), .S_DATA_BITS(8), .M_DATA_BITS(8), .COUNT_BITS(16), .SATURATE(1'b0))
        u_dut2 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
                .m_data(md2), .m_overflow(mo2), .m_count(mc2), .m_valid(mv2));
    elixirchip_es1_spu_op_acc #(.LATENCY(4), .S_DATA_BITS(8), .M_DATA_BITS(16), .COUNT_BITS(2), .SATURATE(1'b0))
        u_dut3 (.clk(clk), .reset(reset), .cke(cke), .s_data(s_data), .s_clear(s_clear), .s_valid(s_valid),
                .m_data(md3), .m_overflow(mo3), .m_count(mc3), .m_valid(mv3));

    logic signed [63:0] act_data [4];
    logic [15:0]        act_cnt  [4];
    logic               act_ovf  [4];
    logic               act_valid[4];

    assign act_data[0] = 64'($signed(md0));
    assign act_data[1] = 64'($signed(md1));
    assign act_data[2] = 64'($signed(md2));
    assign act_data[3] = 64'($signed(md3));
    assign act_cnt[0]  = mc0;
    assign act_cnt[1]  = mc1;
    assign act_cnt[2]  = mc2;
    assign act_cnt[3]  = 16'(mc3);
    assign act_ovf[0]  = mo0;
    assign act_ovf[1]  = mo1;
    assign act_ovf[2]  = mo2;
    assign act_ovf[3]  = mo3;
    assign act_valid[0] = mv0;
    assign act_valid[1] = mv1;
    assign act_valid[2] = mv2;
    assign act_valid[3] = mv3;

    // Reference model: running sum per configuration, plus the history of
    // terms accepted on enabled edges so each latency can pick its own term.
    longint             mdl_acc [4];
    bit                 mdl_ovf [4];
    longint             mdl_cnt [4];
    term_t              hist[$];
    logic signed [63:0] exp_data [4];
    logic [15:0]        exp_cnt  [4];
    logic               exp_ovf  [4];
    logic               exp_valid[4];

    int checks = 0;
    int errors = 0;

    task automatic model_apply(input int i, input term_t t);
        longint lim_hi, lim_lo, modv, sum, w;
        bit     ovf;
        if (!t.valid) begin
            exp_valid[i] = 1'b0;
            return;
        end
        exp_valid[i] = 1'b1;
        lim_hi = (longint'(1) << (P_M[i] - 1)) - 1;
        lim_lo = -(longint'(1) << (P_M[i] - 1));
        modv   = longint'(1) << P_M[i];
        if (t.clear) begin
            mdl_acc[i] = t.data;
            mdl_ovf[i] = 1'b0;
            mdl_cnt[i] = 1;
        end else begin
            sum = mdl_acc[i] + t.data;
            ovf = (sum > lim_hi) || (sum < lim_lo);
            if (ovf && P_SAT[i]) begin
                mdl_acc[i] = (sum > 0) ? lim_hi : lim_lo;
            end else begin
                w = sum & (modv - 1);
                if (w >= modv / 2) w = w - modv;
                mdl_acc[i] = w;
            end
            mdl_ovf[i] = mdl_ovf[i] | ovf;
            if (mdl_cnt[i] < (longint'(1) << P_CB[i]) - 1) mdl_cnt[i] = mdl_cnt[i] + 1;
        end
        exp_data[i] = mdl_acc[i];
        exp_ovf[i]  = mdl_ovf[i];
        exp_cnt[i]  = 16'(mdl_cnt[i]);
    endtask

    task automatic model_edge(input stim_t s);
        term_t t;
        if (s.rst) begin
            hist.delete();
            for (int i = 0; i < 4; i++) begin
                mdl_acc[i] = 0; mdl_ovf[i] = 1'b0; mdl_cnt[i] = 0;
                exp_data[i] = '0; exp_ovf[i] = 1'b0; exp_cnt[i] = '0; exp_valid[i] = 1'b0;
            end
        end else if (s.ce) begin
            t.valid = s.vld;
            t.clear = s.clr;
            t.data  = longint'(s.d);
            hist.push_back(t);
            for (int i = 0; i < 4; i++) begin
                if (hist.size() >= P_LAT[i]) model_apply(i, hist[hist.size() - P_LAT[i]]);
                else exp_valid[i] = 1'b0;
            end
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    // One clock: drive inputs mid-cycle, advance the model at the edge, and
    // leave time #1 past the edge for sampling.
    task automatic drive(input stim_t s);
        @(negedge clk);
        reset   = s.rst;
        cke     = s.ce;
        s_valid = s.vld;
        s_clear = s.clr;
        s_data  = s.d;
        @(posedge clk);
        model_edge(s);
        #1;
    endtask

    function automatic stim_t term(input bit clr, input int d);
        stim_t s;
        s.rst = 1'b0; s.ce = 1'b1; s.vld = 1'b1; s.clr = clr; s.d = 8'(d);
        return s;
    endfunction

    function automatic stim_t idle(input bit ce);
        stim_t s;
        s.rst = 1'b0; s.ce = ce; s.vld = 1'b0; s.clr = 1'b0; s.d = 8'($urandom);
        return s;
    endfunction

    task automatic test_reset();
        stim_t s;
        for (int k = 0; k < 3; k++) begin
            s = idle(k[0]);
            s.rst = 1'b1; s.vld = 1'b1;
            drive(s);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_data[i] !== 64'sd0 || act_ovf[i] !== 1'b0 || act_cnt[i] !== 16'd0 || act_valid[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset k%0d dut%0d: got data=%0d ovf=%b cnt=%0d valid=%b, expected all zero",
                             k, i, act_data[i], act_ovf[i], act_cnt[i], act_valid[i]);
                end
            end
        end
    endtask

    task automatic run_table(input string name, input stim_t tbl[$]);
        foreach (tbl[k]) begin
            drive(tbl[k]);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (act_data[i] !== exp_data[i] || act_ovf[i] !== exp_ovf[i] ||
                    act_cnt[i] !== exp_cnt[i] || act_valid[i] !== exp_valid[i]) begin
                    errors++;
                    $display("FAIL %s step%0d dut%0d: got data=%0d ovf=%b cnt=%0d valid=%b, expected data=%0d ovf=%b cnt=%0d valid=%b",
                             name, k, i, act_data[i], act_ovf[i], act_cnt[i], act_valid[i],
                             exp_data[i], exp_ovf[i], exp_cnt[i], exp_valid[i]);
                end
            end
        end
    endtask

    task automatic test_basic();
        stim_t tbl[$];
        int    want[3] = '{10, 7, 12};
        tbl = '{term(1, 10), term(0, -3), term(0, 5), idle(1), idle(1), idle(1)};
        run_table("basic", tbl);
        // Re-run and pin the 16-bit wrap configuration to the known sums.
        tbl = '{term(1, 10), term(0, -3), term(0, 5), idle(1)};
        drive(tbl[0]);
        for (int k = 0; k < 3; k++) begin
            drive(tbl[k+1]);
            checks++;
            if (act_data[0] !== 64'(want[k]) || act_cnt[0] !== 16'(k + 1) || act_ovf[0] !== 1'b0) begin
                errors++;
                $display("FAIL basic_fixed k%0d: got data=%0d cnt=%0d ovf=%b, expected data=%0d cnt=%0d ovf=0",
                         k, act_data[0], act_cnt[0], act_ovf[0], want[k], k + 1);
            end
        end
        tbl = '{idle(1), idle(1), idle(1)};
        run_table("basic_drain", tbl);
    endtask

    task automatic test_saturate();
        stim_t tbl[$];
        int    want_sat[4] = '{100, 127, 117, 5};
        bit    want_ovf[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl = '{term(1, 100), term(0, 100), term(0, -10), term(1, 5), idle(1)};
        drive(tbl[0]);
        for (int k = 0; k < 4; k++) begin
            drive(tbl[k+1]);
            checks++;
            if (act_data[1] !== 64'(want_sat[k]) || act_ovf[1] !== want_ovf[k]) begin
                errors++;
                $display("FAIL saturate k%0d: got data=%0d ovf=%b, expected data=%0d ovf=%b",
                         k, act_data[1], act_ovf[1], want_sat[k], want_ovf[k]);
            end
            if (k == 1) begin
                checks++;
                if (act_data[2] !== -64'sd56 || act_ovf[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap: got data=%0d ovf=%b, expected data=-56 ovf=1", act_data[2], act_ovf[2]);
                end
            end
        end
        tbl = '{term(1, 100), term(0, 100), term(0, -10), term(1, 5), idle(1), idle(1), idle(1), idle(1)};
        run_table("saturate", tbl);
    endtask

    task automatic test_gaps_cke();
        stim_t tbl[$];
        stim_t frozen;
        frozen = term(0, 2);
        frozen.ce = 1'b0;
        tbl = '{term(1, 1), idle(1), idle(1), frozen, frozen, idle(1), term(0, 2),
                idle(1), idle(0), idle(1), idle(1), idle(1), idle(1)};
        run_table("gaps_cke", tbl);
    endtask

    task automatic test_reset_mid();
        stim_t tbl[$];
        stim_t rst_s;
        rst_s = idle(0);
        rst_s.rst = 1'b1;
        tbl = '{term(1, 50), idle(1), idle(1), idle(1), rst_s, term(0, 4), idle(1), idle(1), idle(1), idle(1)};
        run_table("reset_mid", tbl);
        // Reset while terms are still inside the pipe drops them.
        tbl = '{term(1, 20), term(0, 7), rst_s, idle(1), idle(1), idle(1), idle(1)};
        run_table("reset_inflight", tbl);
    endtask

    task automatic test_count_sat();
        stim_t tbl[$];
        tbl = '{term(1, 0), term(0, 1), term(0, 1), term(0, 1), term(0, 1), term(0, 1),
                idle(1), idle(1), idle(1), idle(1)};
        run_table("count_sat", tbl);
        checks++;
        if (act_data[3] !== 64'sd5 || act_cnt[3] !== 16'd3) begin
            errors++;
            $display("FAIL count_sat_end: got data=%0d cnt=%0d, expected data=5 cnt=3", act_data[3], act_cnt[3]);
        end
    endtask

    task automatic test_random();
        stim_t tbl[$];
        stim_t s;
        for (int k = 0; k < 400; k++) begin
            s.rst = ($urandom_range(0, 59) == 0);
            s.ce  = ($urandom_range(0, 99) < 85);
            s.vld = ($urandom_range(0, 99) < 70);
            s.clr = ($urandom_range(0, 99) < 12);
            s.d   = 8'($urandom);
            tbl.push_back(s);
        end
        run_table("random", tbl);
    endtask

    initial begin
        reset = 1'b1; cke = 1'b0; s_valid = 1'b0; s_clear = 1'b0; s_data = '0;
        for (int i = 0; i < 4; i++) begin
            mdl_acc[i] = 0; mdl_ovf[i] = 1'b0; mdl_cnt[i] = 0;
            exp_data[i] = '0; exp_ovf[i] = 1'b0; exp_cnt[i] = '0; exp_valid[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_saturate();
        test_gaps_cke();
        test_reset_mid();
        test_count_sat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/elixirchip_es1_spu_op_acc.md
Name: elixirchip_es1_spu_op_acc

Overview:
Signed accumulator stage that sits directly downstream of the SPU multiplier. It consumes the multiplier's product stream and sums successive products into a wide register, completing the multiply-accumulate (MAC) path. s_clear marks the first term of a new sum. The block offers optional saturation, a sticky overflow flag and a term counter, and uses the same cke/valid/clear streaming convention as the other SPU op blocks.

Parameters:
- LATENCY, 2: input-to-output latency in cycles; must be ≥2; cycles beyond 2 are added by a delay line.
- S_DATA_BITS, 64: s_data width (signed); must be ≤ M_DATA_BITS.
- M_DATA_BITS, 64: accumulator and m_data width (signed).
- COUNT_BITS, 16: m_count width.
- SATURATE, 1'b0: 1 = clamp on overflow; 0 = two's-complement wrap.
- DEVICE, "RTL": device name, passed through.
- SIMULATION, "false": passed through.
- DEBUG, "false": passed through.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous reset, active-high
- cke  input  1  clock enable
- s_data  input  S_DATA_BITS  signed term (multiplier product)
- s_clear  input  1  with s_valid: this term starts a new sum
- s_valid  input  1  term valid
- m_data  output  M_DATA_BITS  signed running sum
- m_overflow  output  1  sticky: overflow occurred since the last clear
- m_count  output  COUNT_BITS  terms accumulated since the last clear (saturating)
- m_valid  output  1  output updated this cycle

Behaviour:
- Reset and clock enable:
  - Reset acts on the clock edge regardless of cke.
  - On reset, every register (including delay-line stages) goes to 0, so m_data=0, m_overflow=0, m_count=0, m_valid=0.
  - With cke=0 and no reset, all state holds.
- Stage 0 (registered when cke=1): capture s_data (sign-extended to M_DATA_BITS), s_clear and s_valid.
- Stage 1 (registered when cke=1):
  - If st0_valid and st0_clear: acc <= term, ovf <= 0, cnt <= 1.
  - If st0_valid and not st0_clear: sum = acc + term, computed at M_DATA_BITS+1 bits. Overflow exists when the top two bits of sum differ.
    - SATURATE=1 with overflow: acc <= +2^(M-1)-1 if sum is positive, else -2^(M-1).
    - Otherwise: acc <= sum[M-1:0].
    - ovf <= ovf | overflow.
    - cnt <= cnt+1, saturating at all-ones (no wrap).
  - If st0_valid=0: acc, ovf and cnt hold. st1_valid <= st0_valid.
- Latency:
  - Outputs reflect a term exactly LATENCY cke-enabled cycles after it is presented.
  - LATENCY=2: outputs come directly from stage 1.
  - LATENCY>2: outputs pass through a delay line of LATENCY-2 registers, which also hold under cke=0 and reset to 0.
  - m_valid tracks the term's s_valid through the same pipe.
- Output hold: while no valid term arrives, m_data, m_overflow and m_count hold their last values; m_valid=0.
- Clear without prior sum: a valid term with s_clear=1 restarts cleanly at any time, including the first term after reset.
- Non-clear first term after reset: accumulates from 0.
- Reset mid-sum: the partial sum is discarded; terms in flight are dropped.

Decomposition:
- Shared package elixirchip_es1_spu_pkg:
  - saturation-limit helper functions (max/min signed for a given width);
  - overflow-detect function (top-two-bit compare).
- Sub-module: reuse elixirchip_es1_spu_op_nop as the LATENCY-2 delay line, DATA_BITS = M_DATA_BITS+1+COUNT_BITS, so m_data, m_overflow and m_count travel together. m_valid is carried as the nop valid path.

Test Plan:
1. S=8, M=16, LATENCY=2: after reset, terms 10(clear), -3, 5 on consecutive cycles -> m_data 10, 7, 12 and m_count 1, 2, 3 at cycles 2, 3, 4; m_overflow=0.
2. M=8, SATURATE=1: 100(clear), 100, -10, then 5(clear) -> m_data 100, 127, 117, 5; m_overflow 0, 1, 1, 0.
3. M=8, SATURATE=0: 100(clear), 100 -> m_data 100, -56; m_overflow 0, 1.
4. Terms 1(clear), 2 separated by 3 idle cycles, plus cke=0 for 2 cycles mid-stream -> m_data holds 1 through gaps and freezes, then 3; m_valid pulses only on term arrival; total latency stretches by exactly the cke-low cycles.
5. Reset asserted with cke=0 after sum 50 -> next cycle all outputs 0; following non-clear term 4 -> m_data 4, m_count 1.
6. LATENCY=4, COUNT_BITS=2: 5 non-clear terms of 1 after clear 0 -> first output 4 cycles after input; m_count saturates at 3; m_data reaches 5.
